// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 keyboard controller slice.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_PARSE = 2'd2
    } ps2_state_e;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Scan-code set 2 to ASCII table: lowercase letters, digits, space and enter.
module ps2_ascii_rom
    import ps2_pkg::*;
(
    input  logic [7:0] scan,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = '0;
        case (scan)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = '0;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops ps2_keyboard FIFO bytes, parses E0/F0 prefixes, tracks the held key.
// Optional ASCII output enabled by macro PS2_KBD_ASCII_EN.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PFX_TMO = 1000000
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             kbd_ready,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    input  logic             ovf_clr,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf
`ifdef PS2_KBD_ASCII_EN
    ,
    output logic [7:0]       ascii,
    output logic             ascii_valid
`endif
);

    localparam int unsigned TMO_W = (PFX_TMO > 1) ? $clog2(PFX_TMO + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (PFX_TMO > 0) ? TMO_W'(PFX_TMO - 1) : '0;

    ps2_state_e       state_q;
    logic [7:0]       byte_q, key_code_q;
    logic             e0_q, f0_q, nextdata_n_q;
    logic             key_ext_q, key_down_q, press_q, release_q, ovf_q;
    logic [TMO_W-1:0] tmo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             same_key_d, is_pfx_d;

    assign same_key_d = key_down_q && (byte_q == key_code_q) && (e0_q == key_ext_q);
    assign is_pfx_d   = (byte_q == PS2_PFX_EXT) || (byte_q == PS2_PFX_BRK);

`ifdef PS2_KBD_ASCII_EN
    logic [7:0] rom_d, ascii_q;
    logic       ascii_valid_q;

    ps2_ascii_rom u_rom (.scan(byte_q), .ascii(rom_d));

    // Captured at parse time so ascii changes together with key_code.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ascii_q       <= '0;
            ascii_valid_q <= 1'b0;
        end else if (state_q == S_PARSE && !is_pfx_d) begin
            if (!f0_q && !same_key_d) begin
                ascii_q       <= e0_q ? 8'h00 : rom_d;
                ascii_valid_q <= !e0_q && (rom_d != 8'h00);
            end else if (f0_q && same_key_d) begin
                ascii_valid_q <= 1'b0;
            end
        end
    end

    assign ascii       = ascii_q;
    assign ascii_valid = ascii_valid_q;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            byte_q       <= '0;
            e0_q         <= 1'b0;
            f0_q         <= 1'b0;
            tmo_q        <= '0;
            nextdata_n_q <= 1'b1;
            key_code_q   <= '0;
            key_ext_q    <= 1'b0;
            key_down_q   <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (kbd_ready) begin
                        byte_q       <= kbd_data;
                        nextdata_n_q <= 1'b0;
                        tmo_q        <= '0;
                        state_q      <= S_POP;
                    end else if ((e0_q || f0_q) && PFX_TMO != 0) begin
                        // A dangling prefix expires so a later make is not misread.
                        if (tmo_q == TMO_LAST) begin
                            e0_q  <= 1'b0;
                            f0_q  <= 1'b0;
                            tmo_q <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                S_POP: begin
                    nextdata_n_q <= 1'b1;
                    state_q      <= S_PARSE;
                end
                S_PARSE: begin
                    state_q <= S_IDLE;
                    if (byte_q == PS2_PFX_EXT) begin
                        e0_q <= 1'b1;
                    end else if (byte_q == PS2_PFX_BRK) begin
                        f0_q <= 1'b1;
                    end else begin
                        if (f0_q) begin
                            if (same_key_d) begin
                                key_down_q <= 1'b0;
                                release_q  <= 1'b1;
                            end
                        end else if (!same_key_d) begin
                            key_code_q <= byte_q;
                            key_ext_q  <= e0_q;
                            key_down_q <= 1'b1;
                            press_q    <= 1'b1;
                            cnt_q      <= cnt_q + 1'b1;
                        end
                        e0_q <= 1'b0;
                        f0_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    nextdata_n_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)             ovf_q <= 1'b0;
        else if (kbd_overflow) ovf_q <= 1'b1;
        else if (ovf_clr)      ovf_q <= 1'b0;
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign key_code       = key_code_q;
    assign key_ext        = key_ext_q;
    assign key_down       = key_down_q;
    assign press_pulse    = press_q;
    assign release_pulse  = release_q;
    assign press_cnt      = cnt_q;
    assign ovf            = ovf_q;

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Consumer and sequencer for the ps2_keyboard receive FIFO: pops bytes via the ready/nextdata_n handshake and parses PS/2 set-2 prefixes (E0 extended, F0 break).
- Tracks the currently held key, a wrapping press counter and a sticky overflow flag.
- Feeds the two bcd7seg digit decoders (key code) and any further display logic (press count).
- Sits between ps2_keyboard and the display path in the top level.

Parameters:
- CNT_W, 8, width of press_cnt.
- PFX_TMO, 1000000, clk cycles a pending E0/F0 prefix survives without a following byte; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on posedge.
- clrn  in  1  asynchronous active-low reset.
- kbd_ready  in  1  ps2_keyboard FIFO non-empty.
- kbd_data  in  8  byte at FIFO head, valid while kbd_ready=1.
- kbd_overflow  in  1  ps2_keyboard FIFO overflow indication.
- kbd_nextdata_n  out  1  pop request to ps2_keyboard, active-low, registered.
- ovf_clr  in  1  clears sticky ovf.
- key_code  out  8  last make code (non-prefix byte).
- key_ext  out  1  key_code was E0-prefixed.
- key_down  out  1  key_code currently held.
- press_pulse  out  1  one-cycle pulse on each new press.
- release_pulse  out  1  one-cycle pulse on release of the held key.
- press_cnt  out  CNT_W  count of new presses, wraps.
- ovf  out  1  sticky overflow.

Behaviour:
- Reset (clrn=0, asynchronous):
  - kbd_nextdata_n=1; key_code=0, key_ext=0, key_down=0, pulses=0, press_cnt=0, ovf=0.
  - Prefix flags cleared, timeout counter=0, FSM=S_IDLE.
  - Reset asserted mid-handshake abandons the byte; it is not re-read.
- FSM S_IDLE -> S_POP -> S_PARSE -> S_IDLE; three cycles per byte, no back-to-back pops.
  - S_IDLE: if kbd_ready, byte_r<=kbd_data, kbd_nextdata_n<=0, go S_POP; else stay.
  - S_POP: kbd_nextdata_n<=1, go S_PARSE. ps2_keyboard samples the low level at the edge ending S_POP.
  - S_PARSE: process byte_r, go S_IDLE. kbd_ready is not sampled here, so the FIFO pointer has settled before the next read.
- Parse rules (S_PARSE):
  - 0xE0: e0_f<=1.
  - 0xF0: f0_f<=1.
  - Other byte with f0_f=1 (break): if key_down and byte_r==key_code and e0_f==key_ext, then key_down<=0 and release_pulse=1. Otherwise ignore (stale break). Clear both flags.
  - Other byte with f0_f=0 (make):
    - If key_down and byte_r==key_code and e0_f==key_ext: typematic repeat, no change.
    - Else: key_code<=byte_r, key_ext<=e0_f, key_down<=1, press_pulse=1, press_cnt<=press_cnt+1 (mod 2^CNT_W).
    - Clear both flags.
  - A new make while a different key is held replaces it (single-key tracking).
- Pulses are registered and high exactly the cycle after S_PARSE.
- Prefix timeout:
  - Counter runs while e0_f|f0_f and FSM is S_IDLE with kbd_ready=0; reset on any pop.
  - Reaching PFX_TMO clears both flags and the counter.
- ovf:
  - Set on any cycle kbd_overflow=1.
  - ovf_clr=1 clears it.
  - Simultaneous set and clear: set wins.
- kbd_data is ignored when kbd_ready=0.

Optional Feature:
- Macro PS2_KBD_ASCII_EN.
- Defined:
  - Extra ports ascii out 8 and ascii_valid out 1.
  - On each press_pulse cycle, ascii=lookup(key_code) (lowercase, digits, space, enter; 0 for unmapped and all key_ext=1 codes).
  - ascii_valid=1 while key_down and ascii!=0.
  - Both registered; reset to 0.
- Undefined: ports absent, no ROM logic.

Decomposition:
- Package ps2_pkg:
  - constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0;
  - FSM state encoding (S_IDLE/S_POP/S_PARSE, 2 bits).
- Sub-module ps2_ascii_rom: combinational 8-bit scan code to ASCII case table; instantiated only under PS2_KBD_ASCII_EN.

Test Plan:
- Byte stream 1C F0 1C ->
  - 1C: press_pulse, key_code=8'h1C, key_down=1, press_cnt=1;
  - F0 1C: release_pulse, key_down=0; press_cnt stays 1;
  - kbd_nextdata_n low exactly 3 single-cycle times.
- Stream E0 75 E0 F0 75 -> key_code=8'h75, key_ext=1, one press, then release; E0 F0 75 with key_ext=0 held gives no release.
- 1C 1C 1C F0 1C -> press_cnt=1 (typematic ignored), one release_pulse.
- 256 distinct press/release pairs -> press_cnt wraps to 0; kbd_overflow pulse -> ovf=1 until ovf_clr; simultaneous overflow and clear -> ovf stays 1.
- F0 alone, then idle PFX_TMO cycles (PFX_TMO=16 in bench), then 1C -> treated as make: press_pulse, key_down=1.
- clrn low while kbd_nextdata_n=0 -> all outputs 0 and kbd_nextdata_n=1 immediately (asynchronously); with PS2_KBD_ASCII_EN, make 1C -> ascii=8'h61, ascii_valid=1.
